// File: rtl/cmd_reply_packer.sv
// Pairs 16-bit command-reply words into 32-bit payload words and frames them as one
// fixed-length inband control packet (header, timestamp, payload, zero pad) for the RX FIFO.
module cmd_reply_packer #(
    parameter int         PKT_WORDS = 128,
    parameter logic [4:0] CTRL_CHAN = 5'h1F
) (
    input  logic        txclk,
    input  logic        reset,
    input  logic [31:0] timestamp_clock,
    input  logic [15:0] rx_databus,
    input  logic        rx_WR,
    input  logic        rx_WR_done,
    output logic        rx_WR_enabled,
    input  logic        have_space,
    output logic        wrreq,
    output logic [31:0] wrdata,
    output logic        overflow,
    output logic [7:0]  debug
);
    localparam int         BUF_WORDS = PKT_WORDS - 2;
    localparam logic [6:0] FILL_MAX  = 7'(BUF_WORDS);
    localparam logic [6:0] LAST_IDX  = 7'(PKT_WORDS - 1);

    typedef enum logic [2:0] {
        S_COLLECT    = 3'd0,
        S_CLOSE      = 3'd1,
        S_WAIT_SPACE = 3'd2,
        S_HDR        = 3'd3,
        S_TS         = 3'd4,
        S_PAYLOAD    = 3'd5,
        S_PAD        = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  fill_q, fill_d;
    logic        pair_half_q, pair_half_d;
    logic [15:0] lo_q, lo_d;
    logic [31:0] ts_q, ts_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [6:0]  rd_idx_q, rd_idx_d;
    logic        rx_en_q, rx_en_d;
    logic        wrreq_q, wrreq_d;
    logic [31:0] wrdata_q, wrdata_d;
    logic        ovf_q, ovf_d;

    logic [31:0] mem [0:BUF_WORDS-1];
    logic        mem_we;
    logic [31:0] mem_wd;
    logic        accept;

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        pair_half_d = pair_half_q;
        lo_d        = lo_q;
        ts_d        = ts_q;
        cnt_d       = cnt_q;
        rd_idx_d    = rd_idx_q;
        ovf_d       = ovf_q;
        wrreq_d     = 1'b0;
        wrdata_d    = '0;
        mem_we      = 1'b0;
        mem_wd      = '0;
        accept      = rx_WR && rx_en_q;

        if (rx_WR && !rx_en_q) ovf_d = 1'b1;

        case (state_q)
            S_COLLECT: begin
                if (accept) begin
                    if (!pair_half_q) begin
                        lo_d = rx_databus;
                        if (fill_q == '0) ts_d = timestamp_clock;
                    end else begin
                        mem_we = 1'b1;
                        mem_wd = {rx_databus, lo_q};
                        fill_d = fill_q + 7'd1;
                    end
                    pair_half_d = !pair_half_q;
                end else if (fill_q == FILL_MAX ||
                             (rx_WR_done && !rx_WR && (fill_q != '0 || pair_half_q))) begin
                    state_d = S_CLOSE;
                end
            end
            S_CLOSE: begin
                // An odd word count leaves a half-filled word; ship it with a zero upper half.
                if (pair_half_q) begin
                    mem_we      = 1'b1;
                    mem_wd      = {16'h0000, lo_q};
                    fill_d      = fill_q + 7'd1;
                    pair_half_d = 1'b0;
                end
                state_d = S_WAIT_SPACE;
            end
            S_WAIT_SPACE: begin
                if (have_space) begin
                    state_d  = S_HDR;
                    wrreq_d  = 1'b1;
                    wrdata_d = {11'd0, CTRL_CHAN, 7'd0, fill_q, 2'b00};
                    cnt_d    = '0;
                end
            end
            S_HDR: begin
                state_d  = S_TS;
                wrreq_d  = 1'b1;
                wrdata_d = ts_q;
                cnt_d    = cnt_q + 7'd1;
                rd_idx_d = '0;
            end
            S_TS, S_PAYLOAD, S_PAD: begin
                // cnt_q is the index of the word currently on wrdata.
                if (cnt_q == LAST_IDX) begin
                    state_d = S_COLLECT;
                    fill_d  = '0;
                end else begin
                    wrreq_d = 1'b1;
                    cnt_d   = cnt_q + 7'd1;
                    if (rd_idx_q < fill_q) begin
                        state_d  = S_PAYLOAD;
                        wrdata_d = mem[rd_idx_q];
                        rd_idx_d = rd_idx_q + 7'd1;
                    end else begin
                        state_d = S_PAD;
                    end
                end
            end
            default: state_d = S_COLLECT;
        endcase

        rx_en_d = (state_d == S_COLLECT) && (fill_d < FILL_MAX);
    end

    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_COLLECT;
            fill_q      <= '0;
            pair_half_q <= 1'b0;
            lo_q        <= '0;
            ts_q        <= '0;
            cnt_q       <= '0;
            rd_idx_q    <= '0;
            rx_en_q     <= 1'b0;
            wrreq_q     <= 1'b0;
            wrdata_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            pair_half_q <= pair_half_d;
            lo_q        <= lo_d;
            ts_q        <= ts_d;
            cnt_q       <= cnt_d;
            rd_idx_q    <= rd_idx_d;
            rx_en_q     <= rx_en_d;
            wrreq_q     <= wrreq_d;
            wrdata_q    <= wrdata_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge txclk) begin
        if (mem_we) mem[fill_q] <= mem_wd;
    end

    assign rx_WR_enabled = rx_en_q;
    assign wrreq         = wrreq_q;
    assign wrdata        = wrdata_q;
    assign overflow      = ovf_q;
    assign debug         = {3'(state_q), pair_half_q, fill_q[3:0]};
endmodule

// File: tb/tb_cmd_reply_packer.sv
// Randomized bench for cmd_reply_packer: a packet-level model builds each expected
// 128-word burst from the 16-bit words sent, and a per-cycle monitor checks every write.
module tb_cmd_reply_packer;
    logic        txclk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] timestamp_clock = '0;
    logic [15:0] rx_databus = '0;
    logic        rx_WR = 1'b0, rx_WR_done = 1'b0, have_space = 1'b0;
    logic        rx_WR_enabled, wrreq, overflow;
    logic [31:0] wrdata;
    logic [7:0]  debug;

    cmd_reply_packer dut (
        .txclk(txclk), .reset(reset), .timestamp_clock(timestamp_clock),
        .rx_databus(rx_databus), .rx_WR(rx_WR), .rx_WR_done(rx_WR_done),
        .rx_WR_enabled(rx_WR_enabled), .have_space(have_space),
        .wrreq(wrreq), .wrdata(wrdata), .overflow(overflow), .debug(debug)
    );

    always #5 txclk = ~txclk;
    always @(negedge txclk) timestamp_clock <= $urandom();

    int          tests = 0, fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_burst [128];
    int          run = 0;
    logic [15:0] pkt_words[$];
    logic [31:0] pkt_ts;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Per-cycle monitor: every write must match the model's next word, bursts must be 128 long.
    always @(negedge txclk) begin
        if (!reset) begin
            run = 0;
            chk("wrreq_in_reset", {31'd0, wrreq}, 32'd0);
        end else if (wrreq === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_write: got %h expected no write", wrdata);
            end else begin
                chk($sformatf("wrdata[%0d]", run), wrdata, exp_q.pop_front());
            end
            if (run < 128) last_burst[run] = wrdata;
            run++;
        end else begin
            if (wrreq !== 1'b0) chk("wrreq_known", {31'd0, wrreq}, 32'd0);
            if (run != 0) begin
                chk("burst_len", run, 128);
                run = 0;
            end
        end
    end

    task automatic put(input logic [15:0] w, input logic done);
        @(negedge txclk); #1;
        if (pkt_words.size() == 0) pkt_ts = timestamp_clock;
        rx_WR = 1'b1; rx_databus = w; rx_WR_done = done;
        pkt_words.push_back(w);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge txclk); #1;
            rx_WR = 1'b0; rx_WR_done = 1'b0;
        end
    endtask

    task automatic finish_pkt();
        @(negedge txclk); #1;
        rx_WR = 1'b0; rx_WR_done = 1'b1;
        @(negedge txclk); #1;
        rx_WR_done = 1'b0;
    endtask

    // Build the expected packet from the collected words, grant space, then follow the burst.
    task automatic emit(input int wait_cyc, input bit abort);
        logic [31:0] pkt[$];
        logic [15:0] lo, hi;
        int n;
        bit done_ok;
        n = (pkt_words.size() + 1) / 2;
        pkt.push_back(32'h001F_0000 | (32'(n) << 2));
        pkt.push_back(pkt_ts);
        for (int i = 0; i < n; i++) begin
            lo = pkt_words[2*i];
            hi = (2*i + 1 < pkt_words.size()) ? pkt_words[2*i+1] : 16'h0000;
            pkt.push_back({hi, lo});
        end
        while (pkt.size() < 128) pkt.push_back(32'h0);
        pkt_words.delete();
        repeat (wait_cyc) @(negedge txclk);
        #1;
        have_space = 1'b1;
        foreach (pkt[i]) exp_q.push_back(pkt[i]);
        @(negedge txclk); #1;
        chk("burst_start", {31'd0, wrreq}, 32'd1);
        have_space = 1'b0;
        if (abort) begin
            done_ok = 1'b0;
            for (int i = 0; i < 100 && !done_ok; i++) begin
                @(negedge txclk); #2;
                if (run >= 40) done_ok = 1'b1;
            end
            chk("reached_word40", {31'd0, done_ok}, 32'd1);
            reset = 1'b0;
            #1;
            chk("async_wrreq_drop", {31'd0, wrreq}, 32'd0);
            chk("async_wrdata_clr", wrdata, 32'd0);
            exp_q.delete();
            repeat (3) @(negedge txclk);
            #1;
            reset = 1'b1;
            @(negedge txclk); #1;
            chk("post_abort_en", {31'd0, rx_WR_enabled}, 32'd1);
            chk("post_abort_ovf", {31'd0, overflow}, 32'd0);
            chk("post_abort_dbg", {27'd0, debug[4:0]}, 32'd0);
        end else begin
            done_ok = 1'b0;
            for (int i = 0; i < 300 && !done_ok; i++) begin
                @(negedge txclk); #2;
                if (wrreq === 1'b0 && exp_q.size() == 0) done_ok = 1'b1;
            end
            chk("burst_done", {31'd0, done_ok}, 32'd1);
        end
    endtask

    initial begin
        logic [15:0] w;
        logic [31:0] full_last;
        int len;

        repeat (3) @(negedge txclk);
        #1;
        chk("rst_wrreq", {31'd0, wrreq}, 32'd0);
        chk("rst_wrdata", wrdata, 32'd0);
        chk("rst_en", {31'd0, rx_WR_enabled}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_dbg", {27'd0, debug[4:0]}, 32'd0);
        reset = 1'b1;
        @(negedge txclk); #1;
        chk("en_after_rst", {31'd0, rx_WR_enabled}, 32'd1);

        // Ping reply
        put(16'h1234, 1'b0); put(16'h0102, 1'b0); finish_pkt();
        emit(4, 1'b0);
        chk("ping_hdr", last_burst[0], 32'h001F0004);
        chk("ping_pl0", last_burst[2], 32'h01021234);
        chk("ping_pad", last_burst[3], 32'h0);
        chk("ping_last", last_burst[127], 32'h0);

        // Read-reg reply, done arriving with the last word
        put(16'h0007, 1'b0); put(16'h0506, 1'b0); put(16'hBEEF, 1'b0); put(16'hDEAD, 1'b1);
        finish_pkt();
        emit(3, 1'b0);
        chk("rreg_hdr", last_burst[0], 32'h001F0008);
        chk("rreg_pl0", last_burst[2], 32'h05060007);
        chk("rreg_pl1", last_burst[3], 32'hDEADBEEF);

        // Odd word count
        put(16'hAAAA, 1'b0); put(16'hBBBB, 1'b0); put(16'hCCCC, 1'b0); finish_pkt();
        emit(3, 1'b0);
        chk("odd_hdr", last_burst[0], 32'h001F0008);
        chk("odd_pl0", last_burst[2], 32'hBBBBAAAA);
        chk("odd_pl1", last_burst[3], 32'h0000CCCC);

        // Done with nothing collected must not produce a packet
        @(negedge txclk); #1;
        have_space = 1'b1; rx_WR_done = 1'b1;
        repeat (6) @(negedge txclk);
        #1;
        chk("empty_dbg", {27'd0, debug[4:0]}, 32'd0);
        chk("empty_en", {31'd0, rx_WR_enabled}, 32'd1);
        have_space = 1'b0; rx_WR_done = 1'b0;

        // Randomized packets
        for (int p = 0; p < 6; p++) begin
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++) begin
                w = 16'($urandom());
                put(w, (i == len - 1) && ($urandom_range(0, 1) == 1));
                if (i != len - 1) gap($urandom_range(0, 2));
            end
            finish_pkt();
            emit($urandom_range(3, 8), 1'b0);
        end

        // Backpressure: 20 cycles without space
        for (int i = 0; i < 5; i++) put(16'($urandom()), 1'b0);
        finish_pkt();
        emit(20, 1'b0);

        // Full buffer: forced close, then a dropped word sets overflow
        chk("ovf_before_full", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 252; i++) put(16'($urandom()), 1'b0);
        full_last = {pkt_words[251], pkt_words[250]};
        @(negedge txclk); #1;
        chk("full_en_low", {31'd0, rx_WR_enabled}, 32'd0);
        rx_WR = 1'b1; rx_databus = 16'hFFFF;
        @(negedge txclk); #1;
        rx_WR = 1'b0;
        chk("full_ovf", {31'd0, overflow}, 32'd1);
        emit(4, 1'b0);
        chk("full_hdr", last_burst[0], 32'h001F01F8);
        chk("full_last", last_burst[127], full_last);

        // Async reset during a burst, then a clean ping
        put(16'h1111, 1'b0); put(16'h2222, 1'b0); finish_pkt();
        emit(3, 1'b1);
        put(16'h1234, 1'b0); put(16'h0102, 1'b0); finish_pkt();
        emit(3, 1'b0);
        chk("reping_hdr", last_burst[0], 32'h001F0004);
        chk("reping_pl0", last_burst[2], 32'h01021234);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cmd_reply_packer.md
Name: cmd_reply_packer

Overview:
- Receiving end of the command-reply word stream that cmd_reader drives on rx_databus/rx_WR/rx_WR_done.
- Collects 16-bit reply words and pairs them into 32-bit payload words.
- Frames them as one 512-byte inband control packet (header, timestamp, payload, zero pad) and writes it to the RX-side USB FIFO.
- Sits on txclk between the command path and the RX packet FIFO feeding the FX2.

Parameters:
PKT_WORDS, 128, packet length in 32-bit words (header + timestamp + payload + pad)
CTRL_CHAN, 5'h1F, channel number placed in header bits [20:16]

Ports:
txclk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
timestamp_clock  in  32  free-running timestamp, latched per packet
rx_databus  in  16  reply word from command reader
rx_WR  in  1  rx_databus valid this cycle
rx_WR_done  in  1  high = reader has no reply pair in progress (end of reply group)
rx_WR_enabled  out  1  packer can accept a word this cycle
have_space  in  1  RX FIFO can take a full PKT_WORDS packet
wrreq  out  1  RX FIFO write strobe
wrdata  out  32  RX FIFO write data
overflow  out  1  sticky: word arrived while rx_WR_enabled low
debug  out  8  {state[2:0], pair_half, fill[3:0]}

Behaviour:
- Reset (async, reset=0): state COLLECT, fill=0, pair_half=0, wrreq=0, wrdata=0, rx_WR_enabled=0, overflow=0, buffer contents don't-care. Outputs update on the first txclk edge after release.
- Internal buffer: (PKT_WORDS-2) x 32, so payload capacity is 126 words. fill is 7 bits and counts completed 32-bit words.
- Word pairing: first 16-bit word of a pair → bits [15:0]; second → bits [31:16], then the word is committed at fill and fill increments. pair_half toggles on each accepted word.
- Timestamp: timestamp_clock is latched on the first accepted word of a packet (fill=0, pair_half=0).
- rx_WR_enabled = 1 only in COLLECT with fill < PKT_WORDS-2, registered.
  - A word is accepted when rx_WR=1 and rx_WR_enabled=1 on the same edge.
  - rx_WR=1 with rx_WR_enabled=0 drops the word and sets overflow.
- COLLECT → CLOSE when either:
  - rx_WR_done=1, no rx_WR this cycle, and (fill>0 or pair_half=1); or
  - fill reaches PKT_WORDS-2, which forces a close.
  - If rx_WR and rx_WR_done are high together, the word is accepted first; close is evaluated on the next cycle.
- CLOSE:
  - If pair_half=1, commit the partial word with [31:16]=0, increment fill, clear pair_half.
  - Deassert rx_WR_enabled; go to WAIT_SPACE.
- WAIT_SPACE: hold until have_space=1, then go to HDR.
- HDR: wrreq=1, wrdata = {11'd0, CTRL_CHAN, 7'd0, fill[6:0], 2'b00}. Payload length is in 32-bit words at bits [8:2], matching the field cmd_reader parses.
- TS: wrreq=1, wrdata = latched timestamp.
- PAYLOAD: wrreq=1, one buffer word per cycle, index 0..fill-1. Read latency is hidden, so wrdata/wrreq stay contiguous with no bubbles.
- PAD: wrreq=1, wrdata=0 until PKT_WORDS total words have been written. Then clear fill and return to COLLECT.
- Total write burst is exactly PKT_WORDS consecutive wrreq cycles, starting the cycle after have_space is sampled high.
- fill=0 with pair_half=0 and rx_WR_done=1 stays in COLLECT; empty packets are never emitted.
- Reset mid-packet aborts the burst: wrreq drops immediately (asynchronously) and the partial packet is lost. The downstream FIFO is flushed by the same reset.

Test Plan:
1. Ping reply: words 0x1234, 0x0102, then rx_WR_done=1, have_space=1 → 128 writes: header 0x001F0004, timestamp latched at first word, 0x01021234, then 125 zeros.
2. Read-reg reply: 4 words 0x0007, 0x0506, 0xBEEF, 0xDEAD → header payload field 2, payload 0x05060007, 0xDEADBEEF.
3. Odd count: 3 words 0xAAAA, 0xBBBB, 0xCCCC, then done → payload 0xBBBBAAAA, 0x0000CCCC; header [8:2]=2.
4. Full: 252 words with rx_WR_done held low → forced close at fill=126; rx_WR_enabled low from then; a 253rd rx_WR sets overflow; header [8:2]=126, no pad words.
5. Backpressure: close with have_space=0 for 20 cycles → no wrreq; burst of exactly 128 starts the cycle after have_space=1.
6. Async reset asserted at word 40 of the burst → wrreq=0 without a clock edge; after release, rx_WR_enabled=1 and a new ping packet frames correctly.
